// File: rtl/serializador_param_if.sv
// Producer-side bundle for serializador_param: load request, word, bit order
// and the serial/status signals returned by the transmitter.
interface serializador_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             msb_first;
  logic [WIDTH-1:0] data_in;
  logic             data_out;
  logic             bit_valid;
  logic             busy;
  logic             data_ready;

  modport master (
    output start, msb_first, data_in,
    input  data_out, bit_valid, busy, data_ready
  );

  modport slave (
    input  start, msb_first, data_in,
    output data_out, bit_valid, busy, data_ready
  );
endinterface

// File: rtl/serializador_param.sv
// Parametrised parallel-to-serial transmitter with selectable bit order,
// busy flag and end-of-word pulse. Define SERIALIZADOR_PARITY_EN to append an even-parity bit.
module serializador_param #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  serializador_param_if.slave  bus
);

`ifdef SERIALIZADOR_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned      CNT_W  = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NBITS - 1);
`ifdef SERIALIZADOR_PARITY_EN
  localparam logic [CNT_W-1:0] DLAST_C = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             msb_q, msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_out_q, data_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             data_ready_q, data_ready_d;
`ifdef SERIALIZADOR_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             accept;

  // The DONE cycle doubles as the idle gap, so a new word may load on the
  // edge that leaves DONE; only SHIFT blocks a start.
  assign accept = bus.start && (state_q != SHIFT);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    msb_d        = msb_q;
    cnt_d        = cnt_q;
    data_out_d   = IDLE_LEVEL;
    bit_valid_d  = 1'b0;
    busy_d       = 1'b0;
    data_ready_d = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
    par_d        = par_q;
`endif

    if (accept) begin
      // First bit goes out straight from data_in; the register keeps the rest.
      state_d     = SHIFT;
      msb_d       = bus.msb_first;
      cnt_d       = '0;
      bit_valid_d = 1'b1;
      busy_d      = 1'b1;
      if (bus.msb_first) begin
        data_out_d = bus.data_in[WIDTH-1];
        shreg_d    = {bus.data_in[WIDTH-2:0], 1'b0};
      end else begin
        data_out_d = bus.data_in[0];
        shreg_d    = {1'b0, bus.data_in[WIDTH-1:1]};
      end
`ifdef SERIALIZADOR_PARITY_EN
      par_d = ^bus.data_in;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          busy_d = 1'b1;
          if (cnt_q == LAST_C) begin
            state_d      = DONE;
            data_ready_d = 1'b1;
          end else begin
            cnt_d       = cnt_q + 1'b1;
            bit_valid_d = 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
            if (cnt_q == DLAST_C) begin
              data_out_d = par_q;
            end else
`endif
            if (msb_q) begin
              data_out_d = shreg_q[WIDTH-1];
              shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              data_out_d = shreg_q[0];
              shreg_d    = {1'b0, shreg_q[WIDTH-1:1]};
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      msb_q        <= 1'b0;
      cnt_q        <= '0;
      data_out_q   <= IDLE_LEVEL;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      data_ready_q <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      msb_q        <= msb_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      data_ready_q <= data_ready_d;
`ifdef SERIALIZADOR_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.busy       = busy_q;
  assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_serializador_param.sv
// Bench for serializador_param (WIDTH=8): directed words, ignored starts,
// continuous start, asynchronous reset, optional parity and random traffic.
module tb_serializador_param;
  localparam int unsigned W      = 8;
  localparam logic        IDLE_L = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
  localparam int unsigned NW = W + 2;
`else
  localparam int unsigned NW = W + 1;
`endif

  typedef struct packed {
    logic d;
    logic v;
    logic b;
    logic r;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ready_cnt;
  int   busy_cnt;
  exp_t q[$];

  serializador_param_if #(.WIDTH(W)) bus ();

  serializador_param #(
    .WIDTH      (W),
    .IDLE_LEVEL (IDLE_L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: an accepted word expands into its per-cycle output slots; a
  // start is taken only once all slots of the previous word have been used.
  task automatic push_word(input logic [W-1:0] d, input logic m);
    for (int n = 0; n < int'(W); n++)
      q.push_back({(m ? d[W-1-n] : d[n]), 1'b1, 1'b1, 1'b0});
`ifdef SERIALIZADOR_PARITY_EN
    q.push_back({^d, 1'b1, 1'b1, 1'b0});
`endif
    q.push_back({IDLE_L, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic step(input logic s, input logic [W-1:0] d, input logic m);
    exp_t e;
    bus.start     = s;
    bus.data_in   = d;
    bus.msb_first = m;
    @(posedge clk);
    if (s && q.size() == 0) push_word(d, m);
    if (q.size() > 0) e = q.pop_front();
    else              e = {IDLE_L, 1'b0, 1'b0, 1'b0};
    #1;
    chk("data_out",   32'(bus.data_out),   32'(e.d));
    chk("bit_valid",  32'(bus.bit_valid),  32'(e.v));
    chk("busy",       32'(bus.busy),       32'(e.b));
    chk("data_ready", 32'(bus.data_ready), 32'(e.r));
    if (bus.data_ready) ready_cnt++;
    if (bus.busy)       busy_cnt++;
  endtask

  task automatic word(input logic [W-1:0] d, input logic m);
    ready_cnt = 0;
    busy_cnt  = 0;
    step(1'b1, d, m);
    for (int i = 0; i < int'(NW); i++) step(1'b0, $urandom(), $urandom());
    chk("word_busy_cycles", 32'(busy_cnt), 32'(NW));
    chk("word_ready_pulses", 32'(ready_cnt), 32'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data_out",   32'(bus.data_out),   32'(IDLE_L));
    chk("rst_bit_valid",  32'(bus.bit_valid),  32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    ready_cnt     = 0;
    busy_cnt      = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.msb_first = 1'b0;
    bus.data_in   = '0;
    #3;
    chk_reset_outputs();
    #5 rst = 1'b1;

    word(8'hA5, 1'b1);
    word(8'hA5, 1'b0);
    word(8'h01, 1'b1);
    word(8'h01, 1'b0);

    // Starts with 8'hFF while an 8'h00 word is in flight must be dropped.
    ready_cnt = 0;
    step(1'b1, 8'h00, 1'b1);
    for (int i = 1; i <= int'(NW); i++)
      step((i == 4 || i == int'(W)), 8'hFF, 1'b1);
    chk("ignored_ready_pulses", 32'(ready_cnt), 32'd1);

    ready_cnt = 0;
    repeat (3 * NW) step(1'b1, 8'h3C, 1'b1);
    chk("continuous_ready_pulses", 32'(ready_cnt), 32'd3);
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // Asynchronous reset after three bits of 8'hA5.
    step(1'b1, 8'hA5, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    #1 rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    word(8'h5A, 1'b0);

`ifdef SERIALIZADOR_PARITY_EN
    step(1'b1, 8'h07, 1'b1);
    repeat (W) step(1'b0, 8'h00, 1'b0);
    chk("parity_07_bit", 32'(bus.data_out), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("parity_07_ready", 32'(bus.data_ready), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    repeat (W) step(1'b0, 8'h00, 1'b0);
    chk("parity_03_bit", 32'(bus.data_out), 32'd0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), W'($urandom()), 1'($urandom()));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete();
        #1 rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
